// File: rtl/compare_seq_if.sv
// Request/response bundle for the sequential comparator.
// master drives the operands and controls; slave returns status, result and flags.
interface compare_seq_if #(
    parameter int N = 8
);
    logic         start;
    logic         clear;
    logic         is_signed;
    logic [2:0]   op;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic         lt_flag;
    logic         eq_flag;
    logic         gt_flag;

    modport master (
        output start, clear, is_signed, op, A, B,
        input  busy, done, result, lt_flag, eq_flag, gt_flag
    );

    modport slave (
        input  start, clear, is_signed, op, A, B,
        output busy, done, result, lt_flag, eq_flag, gt_flag
    );
endinterface

// File: rtl/compare_seq.sv
// Signed/unsigned multi-op comparator that scans CHUNK bits per cycle from the MSB and stops early.
// Latency k+1 cycles from start (k = first differing chunk from MSB, STEPS if equal); start ignored while busy.
module compare_seq #(
    parameter int N     = 8,
    parameter int CHUNK = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    compare_seq_if.slave  bus
);
    localparam int STEPS = N / CHUNK;
    localparam int IW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    generate
        if (N < 2 || CHUNK < 1 || CHUNK > N || (N % CHUNK) != 0) begin : g_bad_params
            $error("compare_seq: N must be >= 2 and a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [2:0] OP_LT  = 3'd0;
    localparam logic [2:0] OP_LE  = 3'd1;
    localparam logic [2:0] OP_GT  = 3'd2;
    localparam logic [2:0] OP_GE  = 3'd3;
    localparam logic [2:0] OP_EQ  = 3'd4;
    localparam logic [2:0] OP_NE  = 3'd5;
    localparam logic [2:0] OP_MIN = 3'd6;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q;
    logic [N-1:0]   a_q, b_q;
    logic [N-1:0]   ab_q, bb_q;
    logic [2:0]     op_q;
    logic           done_q;
    logic [N-1:0]   result_q;
    logic           lt_q, eq_q, gt_q;

    logic           busy;
    logic           finish;
    logic [CHUNK-1:0] ca, cb;
    logic           diff, rel_lt, rel_gt, rel_eq;
    logic [N-1:0]   res_nxt;

    // The biased copies are shifted left as the scan proceeds, so the live chunk is always on top.
    assign ca     = ab_q[N-1 -: CHUNK];
    assign cb     = bb_q[N-1 -: CHUNK];
    assign diff   = (ca != cb);
    assign rel_lt = diff && (ca < cb);
    assign rel_gt = diff && (ca > cb);
    assign rel_eq = !diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (bus.start) state_d = RUN;
                RUN:     if (finish)    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy   = (state_q == RUN);
        finish = (state_q == RUN) && (diff || (idx_q == '0));
    end

    always_comb begin
        res_nxt = '0;
        case (op_q)
            OP_LT:   res_nxt[0] = rel_lt;
            OP_LE:   res_nxt[0] = rel_lt | rel_eq;
            OP_GT:   res_nxt[0] = rel_gt;
            OP_GE:   res_nxt[0] = rel_gt | rel_eq;
            OP_EQ:   res_nxt[0] = rel_eq;
            OP_NE:   res_nxt[0] = !rel_eq;
            OP_MIN:  res_nxt    = rel_gt ? b_q : a_q;
            default: res_nxt    = rel_lt ? b_q : a_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ab_q     <= '0;
            bb_q     <= '0;
            op_q     <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            gt_q     <= 1'b0;
        end else begin
            if (state_q == IDLE && bus.start && !bus.clear) begin
                a_q   <= bus.A;
                b_q   <= bus.B;
                ab_q  <= {bus.A[N-1] ^ bus.is_signed, bus.A[N-2:0]};
                bb_q  <= {bus.B[N-1] ^ bus.is_signed, bus.B[N-2:0]};
                op_q  <= bus.op;
                idx_q <= IW'(STEPS - 1);
            end else if (state_q == RUN && !finish) begin
                ab_q  <= ab_q << CHUNK;
                bb_q  <= bb_q << CHUNK;
                idx_q <= idx_q - IW'(1);
            end

            if (bus.clear) begin
                done_q   <= 1'b0;
                result_q <= '0;
                lt_q     <= 1'b0;
                eq_q     <= 1'b0;
                gt_q     <= 1'b0;
            end else begin
                done_q <= finish;
                if (finish) begin
                    result_q <= res_nxt;
                    lt_q     <= rel_lt;
                    eq_q     <= rel_eq;
                    gt_q     <= rel_gt;
                end
            end
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.lt_flag = lt_q;
    assign bus.eq_flag = eq_q;
    assign bus.gt_flag = gt_q;
endmodule
